// File: rtl/user_input_event_decoder_pkg.sv
// ============================================================================
// user_input_pkg : event codes, source indices and priority for the decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package user_input_pkg;

   localparam logic [2:0] EVT_NONE      = 3'd0;
   localparam logic [2:0] EVT_ROT_LEFT  = 3'd1;
   localparam logic [2:0] EVT_ROT_RIGHT = 3'd2;
   localparam logic [2:0] EVT_CENTER    = 3'd3;
   localparam logic [2:0] EVT_WEST      = 3'd4;
   localparam logic [2:0] EVT_EAST      = 3'd5;
   localparam logic [2:0] EVT_NORTH     = 3'd6;

   localparam int NUM_SRC = 6;
   localparam int NUM_BTN = 4;

   // Source indices double as arbitration priority: lower index wins.
   localparam int SRC_ROT_LEFT  = 0;
   localparam int SRC_ROT_RIGHT = 1;
   localparam int SRC_CENTER    = 2;
   localparam int SRC_WEST      = 3;
   localparam int SRC_EAST      = 4;
   localparam int SRC_NORTH     = 5;

   typedef logic [2:0] evt_code_t;

   function automatic evt_code_t src_code(input int idx);
      case (idx)
         SRC_ROT_LEFT:  return EVT_ROT_LEFT;
         SRC_ROT_RIGHT: return EVT_ROT_RIGHT;
         SRC_CENTER:    return EVT_CENTER;
         SRC_WEST:      return EVT_WEST;
         SRC_EAST:      return EVT_EAST;
         SRC_NORTH:     return EVT_NORTH;
         default:       return EVT_NONE;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/user_input_event_decoder_if.sv
// ============================================================================
// user_input_event_decoder_if : event valid/ready stream plus FIFO status
// Revision: 1.0
// ============================================================================
`default_nettype none

interface user_input_event_decoder_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             evt_valid;
   logic [2:0]       evt_code;
   logic             evt_ready;
   logic [CNT_W-1:0] evt_count;
   logic             overflow;

   modport master (
      output evt_valid,
      output evt_code,
      output evt_count,
      output overflow,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_code,
      input  evt_count,
      input  overflow,
      output evt_ready
   );

endinterface

`default_nettype wire

// File: rtl/user_input_event_decoder_input_debouncer.sv
// ============================================================================
// input_debouncer : 2-flop sync, stability counter, press (0->1) pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module input_debouncer #(
   parameter int DEBOUNCE_CYCLES = 50_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic pulse_o
);
   localparam int               CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level_q;
   logic [CNT_W-1:0] cnt_q;
   logic             pulse_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], raw_i};
         pulse_q <= 1'b0;
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == LAST) begin
            // This cycle is the last of the required differing run.
            level_q <= ~level_q;
            cnt_q   <= '0;
            pulse_q <= ~level_q;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/user_input_event_decoder.sv
// ============================================================================
// user_input_event_decoder : rotary/button inputs -> prioritised event FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module user_input_event_decoder
   import user_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50_000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic rotary_a,
   input  logic rotary_b,
   input  logic rotary_center,
   input  logic btn_west,
   input  logic btn_east,
   input  logic btn_north,
   user_input_event_decoder_if.master evt
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [1:0] rot_a_sync_q;
   logic [1:0] rot_b_sync_q;
   logic       q1_q;
   logic       q2_q;
   logic       q1_prev_q;
   logic       a_s;
   logic       b_s;
   logic       rot_detent;

   assign a_s = rot_a_sync_q[1];
   assign b_s = rot_b_sync_q[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         rot_a_sync_q <= '0;
         rot_b_sync_q <= '0;
         q1_q         <= 1'b0;
         q2_q         <= 1'b0;
         q1_prev_q    <= 1'b0;
      end else begin
         rot_a_sync_q <= {rot_a_sync_q[0], rotary_a};
         rot_b_sync_q <= {rot_b_sync_q[0], rotary_b};
         q1_prev_q    <= q1_q;
         if (a_s & b_s)
            q1_q <= 1'b1;
         else if (!a_s & !b_s)
            q1_q <= 1'b0;
         if (!a_s & b_s)
            q2_q <= 1'b1;
         else if (a_s & !b_s)
            q2_q <= 1'b0;
      end
   end

   assign rot_detent = q1_q & ~q1_prev_q;

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_pulse;

   assign btn_raw = {btn_north, btn_east, btn_west, rotary_center};

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_debounce
      input_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clk     (clk),
         .reset   (reset),
         .raw_i   (btn_raw[gi]),
         .pulse_o (btn_pulse[gi])
      );
   end

   logic [NUM_SRC-1:0] src_evt;

   assign src_evt[SRC_ROT_LEFT]         = rot_detent & ~q2_q;
   assign src_evt[SRC_ROT_RIGHT]        = rot_detent &  q2_q;
   assign src_evt[SRC_NORTH:SRC_CENTER] = btn_pulse;

   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] pending_d;
   logic [NUM_SRC-1:0] grant;
   logic [2:0]         push_code;
   logic               push;
   logic               pop;
   logic               can_push;
   logic               lost;

   logic [2:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] rd_next;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [2:0]       head_q;
   logic [2:0]       head_d;
   logic             valid_q;
   logic             overflow_q;

   assign pop      = valid_q & evt.evt_ready;
   assign can_push = (count_q != CNT_W'(FIFO_DEPTH)) | pop;
   assign rd_next  = rd_ptr_q + PTR_W'(1);

   // Descending scan so the lowest pending index (highest priority) wins.
   always_comb begin
      grant     = '0;
      push_code = EVT_NONE;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            grant     = NUM_SRC'(1) << i;
            push_code = src_code(i);
         end
      end
      if (!can_push) begin
         grant     = '0;
         push_code = EVT_NONE;
      end
   end

   assign push      = |grant;
   assign lost      = |(src_evt & pending_q);
   assign pending_d = (pending_q & ~grant) | (src_evt & ~pending_q);
   assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

   // Head register keeps the last code visible after the FIFO drains.
   always_comb begin
      head_d = head_q;
      if (pop && (count_q > CNT_W'(1)))
         head_d = mem_q[rd_next];
      else if (push && ((count_q == '0) || pop))
         head_d = push_code;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q  <= '0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         head_q     <= EVT_NONE;
         valid_q    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= EVT_NONE;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_q | lost;
         if (push) begin
            mem_q[wr_ptr_q] <= push_code;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop)
            rd_ptr_q <= rd_next;
         count_q <= count_d;
         head_q  <= head_d;
         valid_q <= (count_d != '0);
      end
   end

   assign evt.evt_valid = valid_q;
   assign evt.evt_code  = head_q;
   assign evt.evt_count = count_q;
   assign evt.overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_user_input_event_decoder.sv
// ============================================================================
// tb_user_input_event_decoder : directed tables, corner sequences, random
// stimulus against a queue-based reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_user_input_event_decoder;

   localparam int N     = 8;
   localparam int DEPTH = 4;

   logic clk           = 1'b0;
   logic reset         = 1'b1;
   logic rotary_a      = 1'b0;
   logic rotary_b      = 1'b0;
   logic rotary_center = 1'b0;
   logic btn_west      = 1'b0;
   logic btn_east      = 1'b0;
   logic btn_north     = 1'b0;

   user_input_event_decoder_if #(.FIFO_DEPTH(DEPTH)) evt_bus ();

   user_input_event_decoder #(
      .DEBOUNCE_CYCLES (N),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rotary_a      (rotary_a),
      .rotary_b      (rotary_b),
      .rotary_center (rotary_center),
      .btn_west      (btn_west),
      .btn_east      (btn_east),
      .btn_north     (btn_north),
      .evt           (evt_bus)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (spec rules, queue-based FIFO) -------
   bit m_s1[6];
   bit m_s2[6];
   bit m_q1, m_q2, m_q1p;
   bit m_lvl[4];
   int m_cnt[4];
   bit m_pls[4];
   bit m_pend[6];
   bit m_ovf;
   int m_fifo[$];
   int m_last;
   bit chk_en = 1'b0;

   always @(posedge clk) begin : model
      bit raw[6];
      bit ev[6];
      bit pend_old[6];
      bit pop;
      int g;
      raw = '{rotary_a, rotary_b, rotary_center, btn_west, btn_east, btn_north};
      if (reset) begin
         for (int i = 0; i < 6; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_pend[i] = 0;
         end
         for (int k = 0; k < 4; k++) begin
            m_lvl[k] = 0; m_cnt[k] = 0; m_pls[k] = 0;
         end
         m_q1 = 0; m_q2 = 0; m_q1p = 0; m_ovf = 0; m_last = 0;
         m_fifo.delete();
      end else begin
         pop   = (m_fifo.size() > 0) && (evt_bus.evt_ready === 1'b1);
         ev[0] = m_q1 && !m_q1p && !m_q2;
         ev[1] = m_q1 && !m_q1p &&  m_q2;
         for (int k = 0; k < 4; k++) ev[2+k] = m_pls[k];
         pend_old = m_pend;
         g = -1;
         if (m_fifo.size() < DEPTH || pop)
            for (int i = 0; i < 6; i++)
               if (g < 0 && m_pend[i]) g = i;
         if (pop) void'(m_fifo.pop_front());
         if (g >= 0) begin
            m_fifo.push_back(g + 1);
            m_pend[g] = 0;
         end
         for (int i = 0; i < 6; i++)
            if (ev[i]) begin
               if (pend_old[i]) m_ovf = 1;
               else             m_pend[i] = 1;
            end
         for (int k = 0; k < 4; k++) begin
            m_pls[k] = 0;
            if (m_s2[2+k] == m_lvl[k]) m_cnt[k] = 0;
            else if (m_cnt[k] + 1 >= N) begin
               m_lvl[k] = !m_lvl[k];
               m_cnt[k] = 0;
               m_pls[k] = m_lvl[k];
            end else m_cnt[k]++;
         end
         m_q1p = m_q1;
         if (m_s2[0] && m_s2[1]) m_q1 = 1;
         else if (!m_s2[0] && !m_s2[1]) m_q1 = 0;
         if (!m_s2[0] && m_s2[1]) m_q2 = 1;
         else if (m_s2[0] && !m_s2[1]) m_q2 = 0;
         m_s2 = m_s1;
         m_s1 = raw;
         if (m_fifo.size() > 0) m_last = m_fifo[0];
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("mdl_valid", evt_bus.evt_valid, (m_fifo.size() > 0) ? 1 : 0);
         check("mdl_code",  evt_bus.evt_code,  (m_fifo.size() > 0) ? m_fifo[0] : m_last);
         check("mdl_count", evt_bus.evt_count, m_fifo.size());
         check("mdl_ovf",   evt_bus.overflow,  m_ovf);
      end
   end

   // Accepted events, sampled on the falling edge before the accepting edge.
   int got[$];
   always @(negedge clk) begin
      if (!reset && evt_bus.evt_valid === 1'b1 && evt_bus.evt_ready === 1'b1)
         got.push_back(evt_bus.evt_code);
   end

   // ---------------- directed helpers ------------------------------------
   task automatic rot_seq(input bit b_lead, input int exp_code, input string tag);
      got.delete();
      if (b_lead) rotary_b = 1; else rotary_a = 1;
      tick();
      if (b_lead) rotary_a = 1; else rotary_b = 1;
      tick();
      if (b_lead) rotary_b = 0; else rotary_a = 0;
      tick();
      if (b_lead) rotary_a = 0; else rotary_b = 0;
      tick();
      tick();
      check({tag, "_early"}, evt_bus.evt_valid, 0);
      tick();
      check({tag, "_valid"}, evt_bus.evt_valid, 1);
      check({tag, "_code"},  evt_bus.evt_code,  exp_code);
      repeat (10) tick();
      check({tag, "_nevt"},  got.size(), 1);
      check({tag, "_got"},   (got.size() > 0) ? got[0] : 0, exp_code);
   endtask

   task automatic detent_left();
      rotary_a = 1; tick();
      rotary_b = 1; tick();
      rotary_a = 0; tick();
      rotary_b = 0; tick();
   endtask

   typedef struct {
      logic [3:0]  mask;   // {north, east, west, center}
      int          n;
      logic [11:0] codes;  // code k in bits [3k+2:3k]
   } btn_vec_t;

   btn_vec_t vecs[5];

   initial begin
      vecs[0] = '{mask: 4'b0001, n: 1, codes: {3'd0, 3'd0, 3'd0, 3'd3}};
      vecs[1] = '{mask: 4'b1110, n: 3, codes: {3'd0, 3'd6, 3'd5, 3'd4}};
      vecs[2] = '{mask: 4'b1001, n: 2, codes: {3'd0, 3'd0, 3'd6, 3'd3}};
      vecs[3] = '{mask: 4'b0110, n: 2, codes: {3'd0, 3'd0, 3'd5, 3'd4}};
      vecs[4] = '{mask: 4'b1111, n: 4, codes: {3'd6, 3'd5, 3'd4, 3'd3}};

      evt_bus.evt_ready = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_valid", evt_bus.evt_valid, 0);
      check("rst_code",  evt_bus.evt_code,  0);
      check("rst_count", evt_bus.evt_count, 0);
      check("rst_ovf",   evt_bus.overflow,  0);
      reset = 0;
      repeat (3) tick();

      rot_seq(1'b0, 1, "rot_left");
      rot_seq(1'b1, 2, "rot_right");

      // Center bounce then a clean press
      got.delete();
      for (int i = 0; i < 20; i++) begin
         rotary_center = ((i / 3) % 2 == 1);
         tick();
      end
      rotary_center = 1;
      repeat (N + 3) tick();
      check("ctr_early", evt_bus.evt_valid, 0);
      tick();
      check("ctr_valid", evt_bus.evt_valid, 1);
      check("ctr_code",  evt_bus.evt_code,  3);
      rotary_center = 0;
      repeat (20) tick();
      check("ctr_nevt", got.size(), 1);

      // Table-driven simultaneous button presses
      for (int v = 0; v < 5; v++) begin
         {btn_north, btn_east, btn_west, rotary_center} = vecs[v].mask;
         repeat (N + 3) tick();
         check("tbl_early", evt_bus.evt_valid, 0);
         for (int k = 0; k < vecs[v].n; k++) begin
            tick();
            check("tbl_valid", evt_bus.evt_valid, 1);
            check("tbl_code",  evt_bus.evt_code,  vecs[v].codes[3*k +: 3]);
            check("tbl_count", evt_bus.evt_count, 1);
         end
         tick();
         check("tbl_drained", evt_bus.evt_valid, 0);
         {btn_north, btn_east, btn_west, rotary_center} = 4'b0000;
         repeat (N + 6) tick();
         check("tbl_release", evt_bus.evt_valid, 0);
      end

      // Full FIFO, pending retention and overflow
      got.delete();
      evt_bus.evt_ready = 1'b0;
      repeat (5) detent_left();
      repeat (6) tick();
      check("full_count", evt_bus.evt_count, 4);
      check("full_ovf",   evt_bus.overflow,  0);
      check("full_code",  evt_bus.evt_code,  1);
      detent_left();
      repeat (6) tick();
      check("ovf_set",   evt_bus.overflow,  1);
      check("ovf_count", evt_bus.evt_count, 4);
      evt_bus.evt_ready = 1'b1;
      repeat (15) tick();
      check("drain_n", got.size(), 5);
      begin
         int bad;
         bad = 0;
         foreach (got[i]) if (got[i] != 1) bad++;
         check("drain_codes", bad, 0);
      end
      check("ovf_sticky", evt_bus.overflow, 1);

      // Reset in the middle of a north debounce
      btn_north = 1;
      repeat (4) tick();
      reset = 1;
      tick();
      check("mrst_valid", evt_bus.evt_valid, 0);
      check("mrst_code",  evt_bus.evt_code,  0);
      check("mrst_count", evt_bus.evt_count, 0);
      check("mrst_ovf",   evt_bus.overflow,  0);
      reset = 0;
      repeat (N + 3) tick();
      check("mrst_early", evt_bus.evt_valid, 0);
      tick();
      check("mrst_evt_valid", evt_bus.evt_valid, 1);
      check("mrst_evt_code",  evt_bus.evt_code,  6);
      btn_north = 0;
      repeat (N + 6) tick();

      // Randomised stimulus, checked cycle by cycle against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) rotary_a = ~rotary_a;
         if ($urandom_range(0, 3) == 0) rotary_b = ~rotary_b;
         if ($urandom_range(0, 9) == 0) rotary_center = ~rotary_center;
         if ($urandom_range(0, 9) == 0) btn_west = ~btn_west;
         if ($urandom_range(0, 9) == 0) btn_east = ~btn_east;
         if ($urandom_range(0, 9) == 0) btn_north = ~btn_north;
         evt_bus.evt_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 599) == 0);
         tick();
      end
      reset = 0;
      {rotary_a, rotary_b, rotary_center, btn_west, btn_east, btn_north} = 6'b0;
      evt_bus.evt_ready = 1'b1;
      repeat (40) tick();
      check("end_count", evt_bus.evt_count, 0);
      check("end_valid", evt_bus.evt_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
